hc_secded_dec: RTL and testbench

Parametrised, pipelined Hamming SECDED decoder for extended-Hamming codewords of any data width. It corrects single-bit errors and flags double-bit errors, with saturating error-event counters. It is the receive-side companion of the team's Hamming encoders and sits between a codeword source (memory read port or link) and the data consumer. It uses a valid/ready handshake on both sides.

---
 rtl/hc_secded_dec.sv | 190 +++++++++++++++++++
 tb/tb_hc_secded_dec.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_secded_dec.sv
// ---------------------------------------------------------------------------
// hc_secded_dec
//
// Two-stage pipelined extended-Hamming (SECDED) decoder. It corrects any
// single-bit error, flags double-bit errors, and counts both kinds of error
// events with saturating counters. Valid/ready handshake on both sides.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_valid       input codeword valid
//   o_ready       decoder can accept a codeword (combinational from i_ready)
//   i_code        codeword: bit 0 overall parity, bits 1..N Hamming positions
//   o_valid       output word valid
//   i_ready       consumer accepts the output word
//   o_data        corrected data (raw data when uncorrectable)
//   o_syndrome    syndrome of the delivered word
//   o_err_single  single error detected and corrected
//   o_err_double  uncorrectable error detected
//   i_cnt_clr     synchronous clear of both counters
//   o_corr_cnt    saturating count of delivered single-error words
//   o_dbl_cnt     saturating count of delivered uncorrectable words
// ---------------------------------------------------------------------------
module hc_secded_dec #(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    localparam int R      = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 :
                            (DATA_W <= 57) ? 6 : 7,
    localparam int N      = DATA_W + R,
    localparam int CW_W   = N + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CW_W-1:0]   i_code,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [R-1:0]      o_syndrome,
    output logic              o_err_single,
    output logic              o_err_double,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_corr_cnt,
    output logic [CNT_W-1:0]  o_dbl_cnt
);

    // Codeword position of data bit idx: the idx-th position (counting from
    // 0) that is not a power of two, i.e. 3,5,6,7,9,...
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx && pos == 0) begin
                    pos = p;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [R-1:0]      s1_syn;
    logic              s1_par;
    logic              s2_valid;

    logic [R-1:0]      in_syn;
    logic              in_par;
    logic [DATA_W-1:0] in_data;

    logic [DATA_W-1:0] fix_data;
    logic              fix_single;
    logic              fix_double;

    logic              adv2;
    logic              out_xfer;

    // Stage 2 moves whenever it is empty or the consumer takes its word;
    // stage 1 moves in lock-step with it, so the decoder can take a new word
    // whenever stage 1 is empty or about to drain.
    assign adv2     = !s2_valid || i_ready;
    assign o_ready  = !s1_valid || adv2;
    assign o_valid  = s2_valid;
    assign out_xfer = s2_valid && i_ready;

    // The syndrome is the XOR of the indices of all set Hamming positions and
    // the overall parity covers every bit including bit 0. Only the data
    // bits are kept for stage 1, since correcting a parity bit never changes
    // the delivered data.
    always_comb begin
        in_syn  = '0;
        in_par  = ^i_code;
        in_data = '0;
        for (int p = 1; p <= N; p++) begin
            if (i_code[p]) begin
                in_syn = in_syn ^ p[R-1:0];
            end
        end
        for (int j = 0; j < DATA_W; j++) begin
            in_data[j] = i_code[data_pos(j)];
        end
    end

    // Classify the stage-1 word. With odd overall parity and a syndrome that
    // names a real position (or zero, meaning bit 0 itself) it is a single
    // error; the flip only touches data when the syndrome names a data
    // position. Even parity with a nonzero syndrome, or a syndrome beyond N,
    // cannot be corrected, so the raw data passes through unchanged.
    always_comb begin
        int dp;
        fix_data   = s1_data;
        fix_single = s1_par && (int'(s1_syn) <= N);
        fix_double = (!s1_par && (s1_syn != '0)) ||
                     (s1_par && (int'(s1_syn) > N));
        dp         = 0;
        for (int j = 0; j < DATA_W; j++) begin
            dp = data_pos(j);
            if (fix_single && (int'(s1_syn) == dp)) begin
                fix_data[j] = ~s1_data[j];
            end
        end
    end

    // Stage 1 captures a new word whenever it can accept one. Payload is only
    // loaded with a real word so the registers do not toggle on idle cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (o_ready) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_data <= in_data;
                s1_syn  <= in_syn;
                s1_par  <= in_par;
            end
        end
    end

    // Stage 2 holds the delivered word. Its outputs change only when it
    // advances, which keeps them stable while the consumer stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid     <= 1'b0;
            o_data       <= '0;
            o_syndrome   <= '0;
            o_err_single <= 1'b0;
            o_err_double <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                o_data       <= fix_data;
                o_syndrome   <= s1_syn;
                o_err_single <= fix_single;
                o_err_double <= fix_double;
            end
        end
    end

    // Error counters tick only when a flagged word actually leaves the
    // decoder, stop at all-ones, and a clear wins over a same-cycle tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_corr_cnt <= '0;
            o_dbl_cnt  <= '0;
        end else if (i_cnt_clr) begin
            o_corr_cnt <= '0;
            o_dbl_cnt  <= '0;
        end else begin
            if (out_xfer && o_err_single && (o_corr_cnt != CNT_MAX)) begin
                o_corr_cnt <= o_corr_cnt + 1'b1;
            end
            if (out_xfer && o_err_double && (o_dbl_cnt != CNT_MAX)) begin
                o_dbl_cnt <= o_dbl_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hc_secded_dec.sv
// ---------------------------------------------------------------------------
// tb_hc_secded_dec
//
// Self-checking bench for hc_secded_dec with DATA_W=4, CNT_W=2. Expected
// words come from an independent parity-equation model and are queued when
// a codeword is accepted, then popped when the decoder delivers a word.
// ---------------------------------------------------------------------------
module tb_hc_secded_dec;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 2;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [7:0]       i_code = '0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [3:0]       o_data;
    logic [2:0]       o_syndrome;
    logic             o_err_single;
    logic             o_err_double;
    logic             i_cnt_clr = 1'b0;
    logic [CNT_W-1:0] o_corr_cnt;
    logic [CNT_W-1:0] o_dbl_cnt;

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] syn;
        logic       single;
        logic       dbl;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared = 0;
    int   n_mismatched = 0;
    int   exp_corr = 0;
    int   exp_dbl = 0;

    hc_secded_dec #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_code      (i_code),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_syndrome  (o_syndrome),
        .o_err_single(o_err_single),
        .o_err_double(o_err_double),
        .i_cnt_clr   (i_cnt_clr),
        .o_corr_cnt  (o_corr_cnt),
        .o_dbl_cnt   (o_dbl_cnt)
    );

    // 10-unit clock period, rising edges at 5, 15, 25, ...
    always #5 i_clk = ~i_clk;

    // Reference decoder for the (8,4) extended code written directly from
    // the three parity-check equations.
    function automatic exp_t model(input logic [7:0] c);
        exp_t       e;
        logic [2:0] s;
        logic       p;
        logic [7:0] b;
        b    = c;
        s[0] = b[1] ^ b[3] ^ b[5] ^ b[7];
        s[1] = b[2] ^ b[3] ^ b[6] ^ b[7];
        s[2] = b[4] ^ b[5] ^ b[6] ^ b[7];
        p    = ^b;
        e.syn    = s;
        e.single = p;
        e.dbl    = !p && (s != 3'd0);
        if (p && (s != 3'd0)) begin
            b[s] = ~b[s];
        end
        e.data = {b[7], b[6], b[5], b[3]};
        return e;
    endfunction

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reset values while held in reset, and o_ready right after release.
    task automatic test_reset();
        i_rst_n = 1'b0;
        #12;
        n_compared++;
        if (o_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_valid: got %b, expected 0", o_valid);
        end
        n_compared++;
        if ({o_data, o_syndrome, o_err_single, o_err_double} !== 9'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got data=%b syn=%0d s=%b d=%b, expected all 0",
                     o_data, o_syndrome, o_err_single, o_err_double);
        end
        n_compared++;
        if ({o_corr_cnt, o_dbl_cnt} !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_counters: got corr=%0d dbl=%0d, expected 0/0", o_corr_cnt, o_dbl_cnt);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        n_compared++;
        if (o_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_ready: got %b, expected 1", o_ready);
        end
        exp_corr = 0;
        exp_dbl  = 0;
    endtask

    // Clean, single, parity-bit and double error words back to back, with
    // latency and full-throughput checks and the counters afterwards.
    task automatic test_stream();
        logic [7:0] codes [4];
        int   idx;
        int   got;
        int   first_acc;
        exp_t e;
        codes = '{8'hAA, 8'h8A, 8'hAB, 8'hCA};
        idx = 0;
        got = 0;
        first_acc = -1;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge i_clk);
            i_ready = 1'b1;
            i_valid = (idx < 4);
            i_code  = (idx < 4) ? codes[idx] : 8'h00;
            #1;
            if (o_valid && i_ready) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL stream_extra: got data=%b with nothing expected", o_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_data, o_syndrome, o_err_single, o_err_double} !== e) begin
                        n_mismatched++;
                        $display("[TB] FAIL stream_word%0d: got data=%b syn=%0d s=%b d=%b, expected data=%b syn=%0d s=%b d=%b",
                                 got, o_data, o_syndrome, o_err_single, o_err_double,
                                 e.data, e.syn, e.single, e.dbl);
                    end
                    if (e.single && exp_corr < 3) exp_corr++;
                    if (e.dbl && exp_dbl < 3) exp_dbl++;
                end
                if (got == 0) begin
                    n_compared++;
                    if (cyc - first_acc != 2) begin
                        n_mismatched++;
                        $display("[TB] FAIL stream_latency: got %0d cycles, expected 2", cyc - first_acc);
                    end
                end
                if (got == 3) begin
                    n_compared++;
                    if (cyc - first_acc != 5) begin
                        n_mismatched++;
                        $display("[TB] FAIL stream_throughput: last word after %0d cycles, expected 5", cyc - first_acc);
                    end
                end
                got++;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(i_code));
                if (idx == 0) first_acc = cyc;
                idx++;
            end
        end
        i_valid = 1'b0;
        n_compared++;
        if (got != 4) begin
            n_mismatched++;
            $display("[TB] FAIL stream_timeout: got %0d words, expected 4", got);
        end
        @(negedge i_clk);
        #1;
        n_compared++;
        if (o_corr_cnt !== 2'd2 || o_dbl_cnt !== 2'd1) begin
            n_mismatched++;
            $display("[TB] FAIL stream_counters: got corr=%0d dbl=%0d, expected corr=2 dbl=1", o_corr_cnt, o_dbl_cnt);
        end
    endtask

    // Stall the consumer while three words are offered, then release.
    task automatic test_backpressure();
        logic [7:0] codes [3];
        int   idx;
        int   got;
        logic have_ref;
        logic [8:0] ref_out;
        exp_t e;
        codes = '{8'hAA, 8'h8A, 8'hAB};
        idx = 0;
        have_ref = 1'b0;
        ref_out = '0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge i_clk);
            i_ready = 1'b0;
            i_valid = (idx < 3);
            i_code  = (idx < 3) ? codes[idx] : 8'h00;
            #1;
            if (o_valid) begin
                if (!have_ref) begin
                    ref_out = {o_data, o_syndrome, o_err_single, o_err_double};
                    have_ref = 1'b1;
                end else begin
                    n_compared++;
                    if ({o_data, o_syndrome, o_err_single, o_err_double} !== ref_out) begin
                        n_mismatched++;
                        $display("[TB] FAIL bp_stable: got %b, expected held %b", {o_data, o_syndrome, o_err_single, o_err_double}, ref_out);
                    end
                end
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(i_code));
                idx++;
            end
        end
        n_compared++;
        if (idx != 2) begin
            n_mismatched++;
            $display("[TB] FAIL bp_accepted: got %0d words accepted, expected 2", idx);
        end
        n_compared++;
        if (o_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL bp_ready_low: got %b, expected 0", o_ready);
        end
        n_compared++;
        if (o_data !== 4'b1011) begin
            n_mismatched++;
            $display("[TB] FAIL bp_data: got %b, expected 1011", o_data);
        end
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            @(negedge i_clk);
            i_ready = 1'b1;
            i_valid = (idx < 3);
            i_code  = (idx < 3) ? codes[idx] : 8'h00;
            #1;
            if (cyc == 0) begin
                n_compared++;
                if (o_ready !== 1'b1) begin
                    n_mismatched++;
                    $display("[TB] FAIL bp_ready_rise: got %b, expected 1", o_ready);
                end
            end
            if (o_valid && i_ready) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL bp_extra: got data=%b with nothing expected", o_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_data, o_syndrome, o_err_single, o_err_double} !== e) begin
                        n_mismatched++;
                        $display("[TB] FAIL bp_word%0d: got data=%b syn=%0d s=%b d=%b, expected data=%b syn=%0d s=%b d=%b",
                                 got, o_data, o_syndrome, o_err_single, o_err_double,
                                 e.data, e.syn, e.single, e.dbl);
                    end
                    if (e.single && exp_corr < 3) exp_corr++;
                    if (e.dbl && exp_dbl < 3) exp_dbl++;
                end
                got++;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(i_code));
                idx++;
            end
        end
        i_valid = 1'b0;
        n_compared++;
        if (got != 3 || exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL bp_drain: got %0d words with %0d left, expected 3 with 0 left", got, exp_q.size());
        end
    endtask

    // Counter saturation, explicit clear, and clear racing an error transfer.
    task automatic test_saturation_clear();
        int   idx;
        int   got;
        exp_t e;
        @(negedge i_clk);
        i_valid   = 1'b0;
        i_cnt_clr = 1'b1;
        @(negedge i_clk);
        i_cnt_clr = 1'b0;
        exp_corr  = 0;
        exp_dbl   = 0;
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge i_clk);
            i_ready = 1'b1;
            i_valid = (idx < 5);
            i_code  = 8'h8A;
            #1;
            if (o_valid && i_ready) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL sat_extra: got data=%b with nothing expected", o_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_data, o_syndrome, o_err_single, o_err_double} !== e) begin
                        n_mismatched++;
                        $display("[TB] FAIL sat_word%0d: got data=%b syn=%0d s=%b, expected data=%b syn=%0d s=%b",
                                 got, o_data, o_syndrome, o_err_single, e.data, e.syn, e.single);
                    end
                    if (e.single && exp_corr < 3) exp_corr++;
                end
                got++;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(i_code));
                idx++;
            end
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        #1;
        n_compared++;
        if (o_corr_cnt !== 2'd3 || exp_corr != 3) begin
            n_mismatched++;
            $display("[TB] FAIL sat_corr: got %0d (model %0d), expected 3", o_corr_cnt, exp_corr);
        end
        i_cnt_clr = 1'b1;
        @(negedge i_clk);
        i_cnt_clr = 1'b0;
        #1;
        n_compared++;
        if (o_corr_cnt !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL clr_corr: got %0d, expected 0", o_corr_cnt);
        end
        exp_corr = 0;
        got = 0;
        idx = 0;
        for (int cyc = 0; cyc < 20 && got < 1; cyc++) begin
            @(negedge i_clk);
            i_cnt_clr = 1'b0;
            i_ready = 1'b1;
            i_valid = (idx < 1);
            i_code  = 8'hCA;
            #1;
            if (o_valid && i_ready) begin
                i_cnt_clr = 1'b1;
                n_compared++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if ({o_data, o_syndrome, o_err_single, o_err_double} !== e) begin
                    n_mismatched++;
                    $display("[TB] FAIL clr_word: got data=%b syn=%0d d=%b, expected data=%b syn=%0d d=%b",
                             o_data, o_syndrome, o_err_double, e.data, e.syn, e.dbl);
                end
                got++;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(model(i_code));
                idx++;
            end
        end
        i_valid = 1'b0;
        @(negedge i_clk);
        i_cnt_clr = 1'b0;
        #1;
        n_compared++;
        if (got != 1 || o_dbl_cnt !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL clr_race: got %0d words and dbl=%0d, expected 1 word and dbl=0", got, o_dbl_cnt);
        end
        exp_dbl = 0;
    endtask

    // Fill both stages under stall, then pull reset mid-stream.
    task automatic test_reset_midstream();
        int idx;
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge i_clk);
            i_ready = (cyc < 3);
            i_valid = (cyc == 0) || (cyc >= 3);
            i_code  = (cyc == 0) ? 8'h8A : 8'hAA;
            #1;
        end
        i_valid = 1'b0;
        n_compared++;
        if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_corr_cnt !== 2'd1) begin
            n_mismatched++;
            $display("[TB] FAIL rst_setup: got valid=%b ready=%b corr=%0d, expected 1/0/1", o_valid, o_ready, o_corr_cnt);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_compared++;
        if (o_valid !== 1'b0 || o_corr_cnt !== 2'd0 || o_dbl_cnt !== 2'd0 || o_data !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_midstream: got valid=%b corr=%0d dbl=%0d data=%b, expected 0/0/0/0000",
                     o_valid, o_corr_cnt, o_dbl_cnt, o_data);
        end
        exp_q.delete();
        exp_corr = 0;
        exp_dbl  = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge i_clk);
            #1;
            if (o_valid) idx++;
        end
        n_compared++;
        if (idx != 0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_discard: got %0d stale words after reset, expected 0", idx);
        end
    endtask

    initial begin
        $display("[TB] hc_secded_dec bench start");
        test_reset();
        test_stream();
        test_backpressure();
        test_saturation_clear();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
